// File: rtl/nq_mem_pkg.sv
// Shared definitions for the NanoQuarter data-memory APB path.
package nq_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int NQ_ADDR_W  = 6;
  localparam int NQ_DATA_W  = 16;
  localparam int NQ_TIMEOUT = 15;

  // Width of a counter that must be able to hold the value TIMEOUT.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_dmem_master_if.sv
// Memory-stage request/response and APB bus signals of the data-memory master.
interface apb_dmem_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired flags that the next wait reaches TIMEOUT.
module apb_wait_timer
  import nq_mem_pkg::*;
#(
  parameter int TIMEOUT = NQ_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count wait states, clear on a new request, hold at LIMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Looks one increment ahead so the abort lands on the cycle the count hits TIMEOUT.
  assign expired = (count >= LAST);

endmodule

// File: rtl/apb_dmem_master.sv
// APB master for the data memory: one load/store at a time, SETUP/ACCESS with waits and timeout.
module apb_dmem_master
  import nq_mem_pkg::*;
#(
  parameter int ADDR_W  = NQ_ADDR_W,
  parameter int DATA_W  = NQ_DATA_W,
  parameter int TIMEOUT = NQ_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  apb_dmem_master_if.master bus
);

  apb_state_e        state;
  apb_state_e        state_next;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              req_ready_c;
  logic              psel_c;
  logic              penable_c;
  logic              pwrite_c;
  logic [ADDR_W-1:0] paddr_c;
  logic [DATA_W-1:0] pwdata_c;
  logic              stall_c;

  logic              accept;
  logic              in_access;
  logic              wait_en;
  logic              expired;
  logic              abort;

  assign accept    = bus.req_valid & req_ready_c;
  assign in_access = (state == ST_ACCESS);
  assign wait_en   = in_access & ~bus.pready;
  assign abort     = wait_en & expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wait_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: pready takes priority over an expiring timer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (bus.pready || abort) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: bus address/data only driven outside IDLE.
  always_comb begin
    req_ready_c = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    pwrite_c    = 1'b0;
    paddr_c     = '0;
    pwdata_c    = '0;
    case (state)
      ST_IDLE: begin
        req_ready_c = rst;
      end
      ST_SETUP: begin
        psel_c   = 1'b1;
        pwrite_c = write_q;
        paddr_c  = addr_q;
        pwdata_c = wdata_q;
      end
      ST_ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        pwrite_c  = write_q;
        paddr_c   = addr_q;
        pwdata_c  = wdata_q;
      end
      default: ;
    endcase
    // Held in reset as well, so the pipeline never runs ahead of the memory port.
    stall_c = ~rst | (state != ST_IDLE) | (bus.req_valid & ~req_ready_c);
  end

  // Capture the accepted request; reset discards any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response registers: one-cycle valid pulse, data/error held until next completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (in_access && bus.pready) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= write_q ? '0 : bus.prdata;
        rsp_err_q   <= bus.pslverr;
      end else if (abort) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.stall     = stall_c;
  assign bus.psel      = psel_c;
  assign bus.penable   = penable_c;
  assign bus.pwrite    = pwrite_c;
  assign bus.paddr     = paddr_c;
  assign bus.pwdata    = pwdata_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_dmem_master.md
# apb_dmem_master

APB master for the NanoQuarter data memory. It accepts one load/store request at a time from the memory stage of the processor pipeline, runs the two-phase APB transfer (SETUP, ACCESS) with wait-state support, and returns read data plus an error flag. While a transfer is in flight it holds the pipeline through `stall`. It sits between the memory stage and the APB data-memory slave, and replaces ad-hoc `memenable`/`memselect`/`memwrite` glue with a real protocol engine.

## Interface
- `ADDR_W`, 6, data-memory word address width
- `DATA_W`, 16, data word width
- `TIMEOUT`, 15, ACCESS cycles with `pready`=0 before abort (≥1)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset: synchronous, active-low
- `req_valid`  in  1  memory stage has a request
- `req_ready`  out  1  block can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  store data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  load data (0 for stores and aborts)
- `rsp_err`  out  1  slave error or timeout, valid with `rsp_valid`
- `stall`  out  1  pipeline hold
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_W;  `pwdata`  out  DATA_W  APB address/data
- `pready`, `pslverr`  in  1;  `prdata`  in  DATA_W  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `req_ready`=1, `psel`=`penable`=0. A request is accepted when `req_valid`&`req_ready` at a rising edge. On acceptance, `req_write`/`req_addr`/`req_wdata` are registered, the wait counter is cleared, and the FSM moves to SETUP.
- SETUP: `psel`=1, `penable`=0. The FSM moves to ACCESS unconditionally.
- ACCESS: `psel`=`penable`=1.
  - `pready`=1: capture `prdata` (load) or 0 (store) into `rsp_rdata`, capture `pslverr` into `rsp_err`, pulse `rsp_valid`, go to IDLE.
  - `pready`=0: increment the wait counter. When the counter reaches `TIMEOUT`, abort: `rsp_rdata`=0, `rsp_err`=1, pulse `rsp_valid`, go to IDLE.
- `paddr`, `pwrite` and `pwdata` come from the registered request and are stable from SETUP to the end of ACCESS. They are 0 in IDLE.
- `req_ready` = (state==IDLE) & `rst`.
- `stall` = (state!=IDLE) | (`req_valid` & ~`req_ready`).
- Requests presented while not ready are ignored and are not queued. The upstream stage must hold them.
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates, so it never wraps.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counter 0. `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err` are 0. `req_ready`=0 and `stall`=1 while `rst` is low.
- Reset mid-transfer: `psel` drops on the next edge, no `rsp_valid` is issued, and the captured request is discarded.
- Accept at edge N. SETUP in cycle N+1, ACCESS from N+2.
  - Zero-wait slave: `rsp_valid` in cycle N+3 and `req_ready`=1 in N+3.
  - With k wait states: `rsp_valid` at N+3+k.
- Peak throughput is one transfer per 3 cycles.
- Timeout: with `pready` held 0, `rsp_valid`+`rsp_err` arrive in cycle N+2+`TIMEOUT`.
- `pready` arriving in the same cycle that the counter hits `TIMEOUT`: `pready` wins, and the response is normal.
- `rsp_valid` is never high for two consecutive cycles.
- `rsp_rdata`/`rsp_err` hold their values until the next completion.

## Structure
- Shared package `nq_mem_pkg`:
  - state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - default `ADDR_W`/`DATA_W`
  - default `TIMEOUT`
- Sub-module `apb_wait_timer`: clear, enable and saturating count, with an `expired` output. It is instantiated once.
- The FSM and the request/response registers live in `apb_dmem_master`.

## Test plan
- Zero-wait load: slave `prdata`=16'hBEEF, load addr 6'h05 accepted at N → SETUP N+1 with `paddr`=5, ACCESS N+2, `rsp_valid`=1 and `rsp_rdata`=16'hBEEF in N+3, `stall` high N+1..N+2.
- Store with 2 waits: addr 6'h3F, data 16'h1234 → `pwrite`=1, `pwdata`=16'h1234 stable SETUP..ACCESS, `rsp_valid` at N+5, `rsp_rdata`=0, `rsp_err`=0.
- Slave error: load with `pslverr`=1 on the `pready` cycle → `rsp_err`=1 with `rsp_valid`; next request accepted normally.
- Timeout: `pready` stuck 0, `TIMEOUT`=15 → `psel` drops, `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at N+17. Repeat with `pready`=1 exactly at the expiry cycle → normal completion.
- Back-to-back: `req_valid` held high with 3 requests → accepts at N, N+3, N+6, and `req_ready` is 0 in the other cycles.
- Reset mid-ACCESS: `rst`=0 during ACCESS → `psel`=`penable`=0 and all outputs 0 after the edge, no `rsp_valid`; after release a fresh load completes correctly.
